// File: rtl/reg_bank_pkg.sv
// Shared types and defaults for the register bank.
// Optional byte-strobe feature is selected with REG_BANK_WSTRB_EN.
package reg_bank_pkg;

   typedef enum logic [1:0] {
      RW  = 2'd0,
      RO  = 2'd1,
      W1C = 2'd2
   } reg_mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } bank_state_e;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_NUM_REGS   = 9;
   localparam int STRB_WIDTH     = DEF_DATA_WIDTH / 8;

   // Per-register defaults used to fill the parameter arrays of the top level.
   localparam reg_mode_e DEF_REG_MODE  = RW;
   localparam bit        DEF_RESET_EN  = 1'b1;
   localparam logic [DEF_DATA_WIDTH-1:0] DEF_RESET_VAL = '0;

   function automatic int strbWidth(input int dataWidth);
      return dataWidth / 8;
   endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Request/response channel of the register bank (valid/ready both ways).
// req_wstrb exists only when REG_BANK_WSTRB_EN is defined.
interface reg_bank_if
   import reg_bank_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
   localparam int STRB_W = strbWidth(DATA_WIDTH);

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
`ifdef REG_BANK_WSTRB_EN
   logic [STRB_W-1:0]     req_wstrb;
`endif
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

`ifdef REG_BANK_WSTRB_EN
   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
`else
   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
`endif

endinterface

// File: rtl/reg_bank_cell.sv
// One register of the bank: access mode, optional reset, byte strobes and
// hardware set pulses (W1C only). RO cells hold no state and read as 0.
module reg_bank_cell
   import reg_bank_pkg::*;
#(
   parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter reg_mode_e             MODE       = RW,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
   parameter bit                    RESET_EN   = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wrEn,
   input  logic [DATA_WIDTH-1:0]   wrData,
   input  logic [DATA_WIDTH/8-1:0] wrStrb,
   input  logic [DATA_WIDTH-1:0]   hwSet,
   output logic [DATA_WIDTH-1:0]   q
);

   generate
      if (MODE == RO) begin : gRo
         logic unusedSig;
         assign unusedSig = ^{clk, rst_n, wrEn, wrData, wrStrb, hwSet};
         assign q = '0;
      end else begin : gStore
         logic [DATA_WIDTH-1:0] qReg;
         logic [DATA_WIDTH-1:0] qNext;
         logic [DATA_WIDTH-1:0] byteMask;
         logic [DATA_WIDTH-1:0] setMask;

         always_comb begin
            byteMask = '0;
            for (int k = 0; k < DATA_WIDTH / 8; k++) begin
               byteMask[8*k +: 8] = {8{wrStrb[k]}};
            end
         end

         assign setMask = (MODE == W1C) ? hwSet : '0;

         // Set is OR-ed in after the bus clear so a coincident set wins.
         always_comb begin
            qNext = qReg;
            if (wrEn) begin
               if (MODE == W1C) begin
                  qNext = qReg & ~(wrData & byteMask);
               end else begin
                  qNext = (qReg & ~byteMask) | (wrData & byteMask);
               end
            end
            qNext = qNext | setMask;
         end

         if (RESET_EN) begin : gRst
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  qReg <= RESET_VAL;
               end else begin
                  qReg <= qNext;
               end
            end
         end else begin : gNoRst
            // No reset: freeze while rst_n is low so the value survives reset.
            always_ff @(posedge clk) begin
               if (rst_n) begin
                  qReg <= qNext;
               end
            end
         end

         assign q = qReg;
      end
   endgenerate

endmodule

// File: rtl/reg_bank.sv
// Register bank top: request FSM, address decode and response register.
// Define REG_BANK_WSTRB_EN to enable per-byte write strobes.
//
//   state | meaning
//   IDLE  | ready for a request; acceptance captures the response
//   RESP  | response held on rsp_*; waits for rsp_ready
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                    NUM_REGS   = DEF_NUM_REGS,
   parameter reg_mode_e             REG_MODE  [NUM_REGS] = '{default: DEF_REG_MODE},
   parameter logic [DATA_WIDTH-1:0] RESET_VAL [NUM_REGS] = '{default: '0},
   parameter bit                    RESET_EN  [NUM_REGS] = '{default: DEF_RESET_EN}
) (
   input  logic                           clk,
   input  logic                           rst_n,
   reg_bank_if.slave                      bus,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rdata,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
   output logic [NUM_REGS-1:0]            wr_pulse
);

   localparam int STRB_W = strbWidth(DATA_WIDTH);

   bank_state_e           state;
   bank_state_e           stateNext;
   logic                  accept;
   logic [NUM_REGS-1:0]   sel;
   logic                  addrOk;
   logic                  selRo;
   logic [DATA_WIDTH-1:0] selRdata;
   logic                  writeOk;
   logic [NUM_REGS-1:0]   wrEn;
   logic [STRB_W-1:0]     strb;
   logic [DATA_WIDTH-1:0] rspRdata;
   logic                  rspErr;

`ifdef REG_BANK_WSTRB_EN
   assign strb = bus.req_wstrb;
`else
   assign strb = '1;
`endif

   // Gating with rst_n keeps requests out while reset is asserted.
   assign bus.req_ready = (state == IDLE) && rst_n;
   assign accept        = bus.req_valid && bus.req_ready;

   always_comb begin
      sel      = '0;
      selRo    = 1'b0;
      selRdata = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (bus.req_addr == ADDR_WIDTH'(i)) begin
            sel[i] = 1'b1;
            selRo  = (REG_MODE[i] == RO);
            selRdata = (REG_MODE[i] == RO) ? hw_rdata[i*DATA_WIDTH +: DATA_WIDTH]
                                           : regs_q[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign addrOk  = |sel;
   assign writeOk = accept && bus.req_write && addrOk && !selRo;
   assign wrEn    = writeOk ? sel : '0;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : gCell
         reg_bank_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .MODE       (REG_MODE[gi]),
            .RESET_VAL  (RESET_VAL[gi]),
            .RESET_EN   (RESET_EN[gi])
         ) uCell (
            .clk    (clk),
            .rst_n  (rst_n),
            .wrEn   (wrEn[gi]),
            .wrData (bus.req_wdata),
            .wrStrb (strb),
            .hwSet  (hw_set[gi*DATA_WIDTH +: DATA_WIDTH]),
            .q      (regs_q[gi*DATA_WIDTH +: DATA_WIDTH])
         );
      end
   endgenerate

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (accept) stateNext = RESP;
         RESP:    if (bus.rsp_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Read data is taken from the flop outputs, i.e. before this edge's update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rspRdata <= '0;
         rspErr   <= 1'b0;
         wr_pulse <= '0;
      end else begin
         wr_pulse <= wrEn;
         if (accept) begin
            rspRdata <= (!bus.req_write && addrOk) ? selRdata : '0;
            rspErr   <= !addrOk || (bus.req_write && selRo);
         end
      end
   end

   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_rdata = rspRdata;
   assign bus.rsp_err   = rspErr;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus randomized traffic
// against a word-level reference model of the register map.
module tb_reg_bank;
   import reg_bank_pkg::*;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int NR = 9;

   localparam reg_mode_e MODES [NR] = '{RW, RW, W1C, RW, RW, RO, RW, W1C, RW};
   localparam logic [DW-1:0] RVALS [NR] = '{32'h0, 32'h1, 32'h0, 32'h0, 32'h0,
                                            32'h0, 32'h0, 32'h0000FF00, 32'h0};
   localparam bit REN [NR] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

   logic clk = 1'b0;
   logic rst_n;
   logic [NR*DW-1:0] hwRdata;
   logic [NR*DW-1:0] hwSet;
   logic [NR*DW-1:0] regsQ;
   logic [NR-1:0]    wrPulse;

   reg_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   reg_bank #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_REGS   (NR),
      .REG_MODE   (MODES),
      .RESET_VAL  (RVALS),
      .RESET_EN   (REN)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .hw_rdata (hwRdata),
      .hw_set   (hwSet),
      .regs_q   (regsQ),
      .wr_pulse (wrPulse)
   );

   always #5 clk = ~clk;

   int testCnt = 0;
   int failCnt = 0;
   logic [DW-1:0] model [NR];
   bit            known [NR];

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      testCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < NR; i++) begin
         if (REN[i]) begin
            model[i] = RVALS[i];
            known[i] = 1'b1;
         end
      end
   endtask

   // One complete transaction; rsp_ready is held low for `hold` cycles after acceptance.
   task automatic txn(input bit wr, input int addr, input logic [DW-1:0] data,
                      input logic [3:0] strb, input int hold);
      logic [DW-1:0] mask;
      logic [DW-1:0] expRdata;
      logic          expErr;
      logic [NR-1:0] expPulse;
      bit            chkRdata;
      int            waitCyc;

      mask = '1;
`ifdef REG_BANK_WSTRB_EN
      for (int k = 0; k < 4; k++) mask[8*k +: 8] = {8{strb[k]}};
`endif
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = AW'(addr);
      bus.req_wdata = data;
`ifdef REG_BANK_WSTRB_EN
      bus.req_wstrb = strb;
`endif
      bus.rsp_ready = (hold == 0);
      waitCyc = 0;
      while (!bus.req_ready && waitCyc < 20) begin
         @(negedge clk);
         waitCyc++;
      end
      check("req_ready_before_accept", {31'b0, bus.req_ready}, 32'h1);

      expErr = 1'b0; expRdata = '0; expPulse = '0; chkRdata = 1'b1;
      if (addr >= NR) begin
         expErr = 1'b1;
      end else if (wr) begin
         if (MODES[addr] == RO) begin
            expErr = 1'b1;
         end else begin
            expPulse[addr] = 1'b1;
            if (MODES[addr] == W1C) model[addr] = model[addr] & ~(data & mask);
            else begin
               model[addr] = (model[addr] & ~mask) | (data & mask);
               if (mask == '1) known[addr] = 1'b1;
            end
         end
      end else begin
         if (MODES[addr] == RO) expRdata = hwRdata[addr*DW +: DW];
         else begin
            expRdata = model[addr];
            chkRdata = known[addr];
         end
      end
      for (int i = 0; i < NR; i++)
         if (MODES[i] == W1C) model[i] = model[i] | hwSet[i*DW +: DW];

      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      hwSet = '0;
      check("rsp_valid_after_accept", {31'b0, bus.rsp_valid}, 32'h1);
      check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, expErr});
      if (chkRdata) check("rsp_rdata", bus.rsp_rdata, expRdata);
      check("wr_pulse_on", {23'b0, wrPulse}, {23'b0, expPulse});
      check("req_ready_low_in_resp", {31'b0, bus.req_ready}, 32'h0);
      if (addr < NR) begin
         if (MODES[addr] == RO) check("regs_q_ro_zero", regsQ[addr*DW +: DW], 32'h0);
         else if (known[addr]) check("regs_q_value", regsQ[addr*DW +: DW], model[addr]);
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("rsp_valid_hold", {31'b0, bus.rsp_valid}, 32'h1);
         check("rsp_err_hold", {31'b0, bus.rsp_err}, {31'b0, expErr});
         if (chkRdata) check("rsp_rdata_hold", bus.rsp_rdata, expRdata);
         check("req_ready_hold", {31'b0, bus.req_ready}, 32'h0);
         if (h == 0) check("wr_pulse_one_cycle", {23'b0, wrPulse}, 32'h0);
      end
      if (hold > 0) bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("rsp_valid_after_handshake", {31'b0, bus.rsp_valid}, 32'h0);
      check("req_ready_after_handshake", {31'b0, bus.req_ready}, 32'h1);
      check("wr_pulse_off", {23'b0, wrPulse}, 32'h0);
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
      bus.req_wdata = '0; bus.rsp_ready = 1'b0;
`ifdef REG_BANK_WSTRB_EN
      bus.req_wstrb = '0;
`endif
      hwRdata = '0; hwSet = '0;
      for (int i = 0; i < NR; i++) begin
         model[i] = 'x;
         known[i] = 1'b0;
      end
      resetModel();

      repeat (3) @(negedge clk);
      check("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
      check("reset_rsp_err", {31'b0, bus.rsp_err}, 32'h0);
      check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
      check("reset_wr_pulse", {23'b0, wrPulse}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_req_ready", {31'b0, bus.req_ready}, 32'h1);
      check("reset_reg1", regsQ[1*DW +: DW], 32'h1);
      check("reset_reg7", regsQ[7*DW +: DW], 32'h0000FF00);

      txn(1'b0, 1, '0, 4'hF, 0);
      txn(1'b1, 1, 32'hDEADBEEF, 4'hF, 0);
      txn(1'b0, 1, '0, 4'hF, 0);

      // W1C: hardware set, then clear racing a new set on bit 0.
      @(negedge clk);
      hwSet[2*DW +: DW] = 32'h0000000F;
      @(negedge clk);
      hwSet = '0;
      model[2] = model[2] | 32'h0000000F;
      check("w1c_after_hw_set", regsQ[2*DW +: DW], model[2]);
      hwSet[2*DW +: DW] = 32'h00000001;
      txn(1'b1, 2, 32'h00000005, 4'hF, 0);
      txn(1'b0, 2, '0, 4'hF, 0);
      check("w1c_set_wins", regsQ[2*DW +: DW], 32'h0000000B);

      txn(1'b1, 5, 32'hCAFEF00D, 4'hF, 0);
      hwRdata[5*DW +: DW] = 32'h00001234;
      txn(1'b0, 5, '0, 4'hF, 0);

      txn(1'b0, 12, '0, 4'hF, 5);
      txn(1'b1, 15, 32'h1, 4'hF, 1);

`ifdef REG_BANK_WSTRB_EN
      txn(1'b1, 1, 32'h0, 4'hF, 0);
      txn(1'b1, 1, 32'hFFFFFFFF, 4'b0010, 0);
      txn(1'b0, 1, '0, 4'hF, 0);
      check("wstrb_byte1", regsQ[1*DW +: DW], 32'h0000FF00);
      txn(1'b1, 1, 32'h12345678, 4'b0000, 0);
      check("wstrb_none", regsQ[1*DW +: DW], 32'h0000FF00);
      txn(1'b1, 7, 32'hFFFFFFFF, 4'b0010, 0);
`endif

      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < NR; i++) hwRdata[i*DW +: DW] = $urandom;
         txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
             4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      end

      // Reset while a response is pending.
      txn(1'b1, 6, 32'h000000AA, 4'hF, 0);
      txn(1'b1, 1, 32'h55555555, 4'hF, 0);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 4'd3;
      bus.rsp_ready = 1'b0;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("inflight_rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
      check("midrst_req_ready", {31'b0, bus.req_ready}, 32'h0);
      check("midrst_reg6_kept", regsQ[6*DW +: DW], 32'h000000AA);
      check("midrst_reg1_reset", regsQ[1*DW +: DW], 32'h1);
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 4'd1;
      bus.req_wdata = 32'h77777777;
`ifdef REG_BANK_WSTRB_EN
      bus.req_wstrb = 4'hF;
`endif
      @(posedge clk); #1;
      check("inrst_no_accept", {31'b0, bus.rsp_valid}, 32'h0);
      check("inrst_no_write", regsQ[1*DW +: DW], 32'h1);
      check("inrst_no_pulse", {23'b0, wrPulse}, 32'h0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      rst_n = 1'b1;
      model[6] = 32'h000000AA;
      resetModel();
      @(posedge clk); #1;
      check("postrst_dropped", {31'b0, bus.rsp_valid}, 32'h0);
      check("postrst_req_ready", {31'b0, bus.req_ready}, 32'h1);
      txn(1'b0, 6, '0, 4'hF, 0);
      txn(1'b0, 1, '0, 4'hF, 0);
      txn(1'b0, 7, '0, 4'hF, 0);

      $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
      $finish;
   end

endmodule
